omni_result_bcast: RTL and testbench

Downstream stage of the OmniReduce aggregation core: takes each aggregated 512-bit block (header `{next_blk_id, 2'b11}`) and replicates it once per worker. Each copy is tagged with that worker's TCP session ID on `tx_TDEST`, so the TCP TX path can return the result to every client. A small session table is loaded from the host. Malformed words and words received with zero workers are dropped and counted.

---
 rtl/omni_result_bcast.sv | 144 ++++++++++++++
 tb/tb_omni_result_bcast.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/omni_result_bcast.sv
// Result broadcaster: replicates each aggregated block once per worker and tags
// every copy with that worker's TCP session ID on tx_TDEST.
module omni_result_bcast #(
    parameter int DATA_W      = 512,
    parameter int SID_W       = 16,
    parameter int MAX_WORKERS = 16,
    parameter int IDX_W       = $clog2(MAX_WORKERS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [29:0]       num_workers,
    input  logic              cfg_we,
    input  logic [IDX_W-1:0]  cfg_idx,
    input  logic [SID_W-1:0]  cfg_sid,
    input  logic [DATA_W-1:0] rx_TDATA,
    input  logic              rx_TVALID,
    output logic              rx_TREADY,
    output logic [DATA_W-1:0] tx_TDATA,
    output logic [SID_W-1:0]  tx_TDEST,
    output logic              tx_TLAST,
    output logic              tx_TVALID,
    input  logic              tx_TREADY,
    output logic [31:0]       blk_cnt,
    output logic [15:0]       drop_cnt
);

    typedef enum logic {IDLE, REP} state_t;

    state_t              state_reg, state_next;
    logic [DATA_W-1:0]   data_reg, data_next;
    logic [SID_W-1:0]    dest_reg, dest_next;
    logic                last_reg, last_next;
    logic [IDX_W-1:0]    idx_reg, idx_next;
    logic [IDX_W:0]      n_eff_reg, n_eff_next;
    logic [31:0]         blk_cnt_reg, blk_cnt_next;
    logic [15:0]         drop_cnt_reg, drop_cnt_next;

    // Session table, flattened so each entry register drives its own slice.
    logic [MAX_WORKERS*SID_W-1:0] table_flat;

    generate
        for (genvar gi = 0; gi < MAX_WORKERS; gi++) begin : g_entry
            logic [SID_W-1:0] sid_reg;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)
                    sid_reg <= '0;
                else if (cfg_we && cfg_idx == IDX_W'(gi))
                    sid_reg <= cfg_sid;
            end
            assign table_flat[gi*SID_W +: SID_W] = sid_reg;
        end
    endgenerate

    logic              accept;
    logic              good_word;
    logic              tx_hs;
    logic [IDX_W:0]    n_eff_in;
    logic [IDX_W-1:0]  idx_inc;
    logic [SID_W-1:0]  sid_first;
    logic [SID_W-1:0]  sid_inc;

    assign tx_TVALID = (state_reg == REP);
    assign rx_TREADY = (state_reg == IDLE) || (state_reg == REP && last_reg && tx_TREADY);
    assign accept    = rx_TVALID && rx_TREADY;
    assign good_word = (rx_TDATA[1:0] == 2'b11) && (num_workers != 30'd0);
    assign tx_hs     = (state_reg == REP) && tx_TREADY;
    assign idx_inc   = idx_reg + IDX_W'(1);
    assign sid_first = table_flat[0 +: SID_W];
    assign sid_inc   = table_flat[int'(idx_inc)*SID_W +: SID_W];

    always_comb begin
        if (num_workers > 30'(MAX_WORKERS))
            n_eff_in = (IDX_W+1)'(MAX_WORKERS);
        else
            n_eff_in = num_workers[IDX_W:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            data_reg     <= '0;
            dest_reg     <= '0;
            last_reg     <= 1'b0;
            idx_reg      <= '0;
            n_eff_reg    <= '0;
            blk_cnt_reg  <= '0;
            drop_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            data_reg     <= data_next;
            dest_reg     <= dest_next;
            last_reg     <= last_next;
            idx_reg      <= idx_next;
            n_eff_reg    <= n_eff_next;
            blk_cnt_reg  <= blk_cnt_next;
            drop_cnt_reg <= drop_cnt_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        data_next     = data_reg;
        dest_next     = dest_reg;
        last_next     = last_reg;
        idx_next      = idx_reg;
        n_eff_next    = n_eff_reg;
        blk_cnt_next  = blk_cnt_reg;
        drop_cnt_next = drop_cnt_reg;

        // Final copy retires the block; an accept may land in that same cycle.
        if (tx_hs) begin
            if (!last_reg) begin
                idx_next  = idx_inc;
                dest_next = sid_inc;
                last_next = ({1'b0, idx_inc} == n_eff_reg - (IDX_W+1)'(1));
            end else begin
                blk_cnt_next = blk_cnt_reg + 32'd1;
                state_next   = IDLE;
            end
        end

        if (accept) begin
            if (good_word) begin
                state_next = REP;
                data_next  = rx_TDATA;
                n_eff_next = n_eff_in;
                idx_next   = '0;
                dest_next  = sid_first;
                last_next  = (n_eff_in == (IDX_W+1)'(1));
            end else begin
                state_next = IDLE;
                if (drop_cnt_reg != 16'hFFFF)
                    drop_cnt_next = drop_cnt_reg + 16'd1;
            end
        end
    end

    assign tx_TDATA = data_reg;
    assign tx_TDEST = dest_reg;
    assign tx_TLAST = last_reg;
    assign blk_cnt  = blk_cnt_reg;
    assign drop_cnt = drop_cnt_reg;

endmodule

// File: tb/tb_omni_result_bcast.sv
// Scoreboard bench for omni_result_bcast: directed scenarios plus randomized traffic
// checked against a per-block replication model.
module tb_omni_result_bcast;

    localparam int DW   = 512;
    localparam int SW   = 16;
    localparam int MAXW = 16;
    localparam int IW   = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [29:0]   num_workers = '0;
    logic          cfg_we = 1'b0;
    logic [IW-1:0] cfg_idx = '0;
    logic [SW-1:0] cfg_sid = '0;
    logic [DW-1:0] rx_TDATA = '0;
    logic          rx_TVALID = 1'b0;
    logic          rx_TREADY;
    logic [DW-1:0] tx_TDATA;
    logic [SW-1:0] tx_TDEST;
    logic          tx_TLAST;
    logic          tx_TVALID;
    logic          tx_TREADY = 1'b0;
    logic [31:0]   blk_cnt;
    logic [15:0]   drop_cnt;

    omni_result_bcast dut (
        .clk(clk), .rst_n(rst_n), .num_workers(num_workers),
        .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_sid(cfg_sid),
        .rx_TDATA(rx_TDATA), .rx_TVALID(rx_TVALID), .rx_TREADY(rx_TREADY),
        .tx_TDATA(tx_TDATA), .tx_TDEST(tx_TDEST), .tx_TLAST(tx_TLAST),
        .tx_TVALID(tx_TVALID), .tx_TREADY(tx_TREADY),
        .blk_cnt(blk_cnt), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] data;
        logic [SW-1:0] dest;
        logic          last;
    } beat_t;

    beat_t       exp_q[$];
    int          hs_times[$];
    logic [SW-1:0] tbl[MAXW];
    int          blk_exp = 0;
    int          drop_exp = 0;
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          rmode = 0;   // 0: ready high, 1: random ready, 2: driven by the test

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        if (rmode == 0) tx_TREADY = 1'b1;
        else if (rmode == 1) tx_TREADY = 1'($urandom_range(0, 1));
    end

    // Monitor: pops one expected beat per handshake and checks AXI hold during stalls.
    beat_t         mb;
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_data;
    logic [SW-1:0] prev_dest;
    logic          prev_last;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("stall_valid", DW'(tx_TVALID), DW'(1));
                chk("stall_data", tx_TDATA, prev_data);
                chk("stall_dest", DW'(tx_TDEST), DW'(prev_dest));
                chk("stall_last", DW'(tx_TLAST), DW'(prev_last));
            end
            if (tx_TVALID && tx_TREADY) begin
                hs_times.push_back(cyc);
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", DW'(1), DW'(0));
                end else begin
                    mb = exp_q.pop_front();
                    chk("beat_data", tx_TDATA, mb.data);
                    chk("beat_dest", DW'(tx_TDEST), DW'(mb.dest));
                    chk("beat_last", DW'(tx_TLAST), DW'(mb.last));
                end
            end
            prev_stall = tx_TVALID && !tx_TREADY;
            prev_data  = tx_TDATA;
            prev_dest  = tx_TDEST;
            prev_last  = tx_TLAST;
        end
    end

    function automatic logic [DW-1:0] make_data(input logic [1:0] hdr);
        logic [DW-1:0] d;
        for (int i = 0; i < DW/32; i++) d[i*32 +: 32] = $urandom;
        d[1:0] = hdr;
        return d;
    endfunction

    // Model: a good word becomes min(nw, MAXW) copies addressed to table entries 0..n-1.
    task automatic model_word(input logic [DW-1:0] d, input int nw);
        int n;
        beat_t b;
        if (d[1:0] == 2'b11 && nw != 0) begin
            n = (nw > MAXW) ? MAXW : nw;
            for (int k = 0; k < n; k++) begin
                b.data = d; b.dest = tbl[k]; b.last = (k == n - 1);
                exp_q.push_back(b);
            end
            blk_exp++;
        end else begin
            drop_exp++;
        end
    endtask

    task automatic cfg_write(input int i, input logic [SW-1:0] s);
        cfg_we = 1'b1; cfg_idx = IW'(i); cfg_sid = s;
        @(posedge clk); #1;
        cfg_we = 1'b0;
        tbl[i] = s;
    endtask

    task automatic send_word(input logic [DW-1:0] d, input int nw, input bit use_model);
        bit ok = 0;
        rx_TDATA = d; num_workers = 30'(nw); rx_TVALID = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (rx_TREADY) begin ok = 1; break; end
        end
        if (!ok) begin
            chk("accept_timeout", DW'(0), DW'(1));
            rx_TVALID = 1'b0;
            return;
        end
        if (use_model) model_word(d, nw);
        @(posedge clk); #1;
        rx_TVALID = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 3000; i++) begin
            if (exp_q.size() == 0) break;
            @(posedge clk);
        end
        if (exp_q.size() != 0) chk("drain_timeout", DW'(exp_q.size()), DW'(0));
        @(posedge clk); #1;
    endtask

    task automatic chk_counters(input string tag);
        chk({tag, "_blk_cnt"}, DW'(blk_cnt), DW'(blk_exp));
        chk({tag, "_drop_cnt"}, DW'(drop_cnt), DW'(drop_exp));
    endtask

    initial begin
        logic [DW-1:0] d;
        logic [SW-1:0] old0;
        beat_t b;
        int rdy[5];
        int rxr[5];
        rdy = '{1, 0, 0, 1, 1};
        rxr = '{0, 0, 0, 0, 1};
        for (int i = 0; i < MAXW; i++) tbl[i] = '0;

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_rx_ready", DW'(rx_TREADY), DW'(1));
        chk("rst_tx_valid", DW'(tx_TVALID), DW'(0));
        chk("rst_tx_last", DW'(tx_TLAST), DW'(0));
        chk("rst_tx_dest", DW'(tx_TDEST), DW'(0));
        chk("rst_tx_data", tx_TDATA, DW'(0));
        chk_counters("rst");
        @(posedge clk); #1;

        // Normal broadcast
        cfg_write(0, 16'h11); cfg_write(1, 16'h22); cfg_write(2, 16'h33);
        d = make_data(2'b11); d[31:0] = 32'h0000_0007;
        send_word(d, 3, 1);
        drain();
        chk_counters("normal");

        // Backpressure with a fixed ready pattern
        rmode = 2; tx_TREADY = 1'b1;
        send_word(make_data(2'b11), 3, 1);
        for (int i = 0; i < 5; i++) begin
            tx_TREADY = 1'(rdy[i]);
            @(negedge clk);
            chk("bp_rx_ready", DW'(rx_TREADY), DW'(rxr[i]));
            @(posedge clk); #1;
        end
        rmode = 0; tx_TREADY = 1'b1;
        drain();
        chk_counters("bp");

        // Back-to-back blocks
        hs_times.delete();
        send_word(make_data(2'b11), 2, 1);
        send_word(make_data(2'b11), 2, 1);
        drain();
        chk("b2b_beats", DW'(hs_times.size()), DW'(4));
        if (hs_times.size() == 4)
            chk("b2b_span", DW'(hs_times[3] - hs_times[0]), DW'(3));
        chk_counters("b2b");

        // Drops and clamp
        send_word(make_data(2'b01), 3, 1);
        drain(); repeat (3) @(posedge clk); #1;
        chk_counters("drop_hdr");
        send_word(make_data(2'b11), 0, 1);
        drain(); repeat (3) @(posedge clk); #1;
        chk_counters("drop_zero");
        for (int i = 3; i < MAXW; i++) cfg_write(i, SW'($urandom));
        hs_times.delete();
        send_word(make_data(2'b11), 40, 1);
        drain();
        chk("clamp_beats", DW'(hs_times.size()), DW'(16));
        chk_counters("clamp");

        // Config race: rewrite entry 0 while copy 0 is stalled, entry 2 before its load
        rmode = 2; tx_TREADY = 1'b0;
        d = make_data(2'b11);
        old0 = tbl[0];
        b.data = d; b.dest = old0;   b.last = 0; exp_q.push_back(b);
        b.data = d; b.dest = tbl[1]; b.last = 0; exp_q.push_back(b);
        b.data = d; b.dest = 16'hBB; b.last = 1; exp_q.push_back(b);
        blk_exp++;
        send_word(d, 3, 0);
        cfg_write(0, 16'hAA);
        @(negedge clk);
        chk("race_dest_hold", DW'(tx_TDEST), DW'(old0));
        @(posedge clk); #1;
        cfg_write(2, 16'hBB);
        rmode = 0; tx_TREADY = 1'b1;
        drain();
        chk_counters("race");

        // Randomized traffic with random backpressure
        for (int it = 0; it < 40; it++) begin
            if ($urandom_range(0, 3) == 0) begin
                drain();
                cfg_write($urandom_range(0, MAXW - 1), SW'($urandom));
            end
            rmode = 1;
            send_word(make_data(($urandom_range(0, 4) == 0) ? 2'($urandom) : 2'b11),
                      $urandom_range(0, 20), 1);
            if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 3)) @(posedge clk);
            #0;
        end
        rmode = 0;
        drain();
        chk_counters("random");

        // Asynchronous reset while copy 1 of 3 is presented
        rmode = 2; tx_TREADY = 1'b1;
        send_word(make_data(2'b11), 3, 1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_tx_valid", DW'(tx_TVALID), DW'(0));
        chk("arst_blk_cnt", DW'(blk_cnt), DW'(0));
        chk("arst_drop_cnt", DW'(drop_cnt), DW'(0));
        exp_q.delete();
        blk_exp = 0; drop_exp = 0;
        for (int i = 0; i < MAXW; i++) tbl[i] = '0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("arst_rx_ready", DW'(rx_TREADY), DW'(1));
        @(posedge clk); #1;
        rmode = 0;
        send_word(make_data(2'b11), 2, 1);
        drain();
        cfg_write(0, 16'h5A); cfg_write(1, 16'h6B); cfg_write(2, 16'h7C);
        send_word(make_data(2'b11), 3, 1);
        drain();
        chk_counters("post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
